cpu_io_bridge: RTL
==================

Name: cpu_io_bridge

Overview:
- Parametrised Z80 I/O-port bridge between the asynchronous CPU bus (address, rd_n/wr_n/iorq_n, 8-bit data) and the VDP register interface.
- Successor to the fixed $98–$9B single-transaction capture logic. Adds:
  - configurable base address and port count;
  - configurable strobe glitch-filter length;
  - a write FIFO with req/ack handshake to the VDP;
  - ordered reads and optional Z80 WAIT generation.

Parameters:
- ADDR_W, 8, CPU I/O address width decoded.
- BASE_ADDR, 8'h98, port block base; low PORT_W bits must be 0.
- NUM_PORTS, 4, ports decoded; power of 2, 2..16. PORT_W = clog2(NUM_PORTS).
- FILTER_LEN, 3, consecutive identical samples required before a filtered strobe changes; 1..8.
- FIFO_DEPTH, 4, write FIFO entries; power of 2, 2..16.

Ports:
- clk in 1: bridge clock; all logic on rising edge.
- reset_n in 1: asynchronous, active-low reset.
- addr_i in ADDR_W: raw CPU address.
- iorq_n_i in 1: raw I/O request, active low.
- rd_n_i in 1: raw read strobe, active low.
- wr_n_i in 1: raw write strobe, active low.
- cd_i in 8: raw CPU data bus (write data).
- cd_o out 8: read data to CPU.
- cd_oe out 1: tristate enable for cd_o.
- wait_n out 1: Z80 WAIT, active low.
- req_o out 1: transaction request to VDP.
- wrt_o out 1: 1 = write, 0 = read; valid while req_o.
- adr_o out PORT_W: port index; valid while req_o.
- dbo_o out 8: write data; valid while req_o.
- ack_i in 1: VDP accepts the transaction on the cycle it is high.
- dbi_i in 8: VDP read data; valid on the ack_i cycle of a read.
- fifo_level_o out clog2(FIFO_DEPTH)+1: write FIFO occupancy.
- ovf_o out 1: sticky write-overflow flag.

Behaviour:

Reset values:
- cd_o=0, cd_oe=0, wait_n=1, req_o=0, wrt_o=0, adr_o=0, dbo_o=0, fifo_level_o=0, ovf_o=0.
- Filtered strobes = 1 (inactive). FSM = IDLE.
- Reset mid-transaction discards FIFO contents and any pending read.

Input conditioning:
- iorq_n/rd_n/wr_n each pass a 2-flop synchroniser, then the filter.
- A filtered output changes only after FILTER_LEN consecutive equal synchronised samples.
- Strobe-to-filtered latency: 2+FILTER_LEN cycles.

Decode:
- hit = ~iorq_f & (addr_i[ADDR_W-1:PORT_W] == BASE_ADDR[ADDR_W-1:PORT_W]).
- Address and data are sampled raw at the acceptance cycle; they are stable by then.

Access classification (IDLE, hit):
- rd_f=0, wr_f=1 → read.
- wr_f=0, rd_f=1 → write.
- Both low → ignored; go to END_WAIT.

FSM states: IDLE, RD_DRAIN, RD_REQ, END_WAIT.
- IDLE, write:
  - Push {port, cd_i} into FIFO, then END_WAIT.
  - If FIFO full: see Optional Feature.
- IDLE, read:
  - Go to RD_DRAIN; cd_oe=1 from the next cycle.
- RD_DRAIN:
  - Wait until FIFO is empty and no write handshake is in flight, so reads never overtake earlier writes. Then RD_REQ.
- RD_REQ:
  - Drive a read request.
  - On ack_i: latch dbi_i into cd_o (visible next cycle), then END_WAIT.
- END_WAIT:
  - Hold until ~hit or rd_f=wr_f=1, then IDLE.
  - cd_oe drops on exiting END_WAIT (read) or immediately if the access ends early.
  - An access that ends during RD_DRAIN or RD_REQ still completes its VDP read; cd_o updates and cd_oe=0.
- Each CPU access produces exactly one transaction.

VDP handshake:
- req_o rises with wrt_o/adr_o/dbo_o stable.
- These hold until the cycle ack_i=1. req_o is 0 on the following cycle.
- The next request may assert one cycle after that (minimum 2 cycles per transaction).
- ack_i while req_o=0 is ignored.
- FIFO head pops on write ack.

FIFO:
- Push and pop in the same cycle: level unchanged.
- A push into a full FIFO that coincides with a pop is accepted.
- fifo_level_o ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: CPU_WAIT_EN.
- With the macro:
  - wait_n=0 from read acceptance until cd_o is updated.
  - wait_n=0 from write acceptance while the FIFO is full; the write is pushed when space frees, then wait_n=1.
  - No write is ever dropped; ovf_o stays 0.
- Without the macro:
  - wait_n tied 1.
  - A write to a full FIFO with no coincident pop is dropped and sets ovf_o (sticky until reset).
  - A read whose CPU strobe ends before data returns leaves the CPU with the previous cd_o value.

Test Plan:
- Write 8'h5A to port 1 (addr 8'h99), ack_i 1 cycle after req → req_o with wrt_o=1, adr_o=1, dbo_o=8'h5A; exactly one req; fifo_level_o returns 0.
- wr_n glitch shorter than FILTER_LEN cycles at addr 8'h98 → no FIFO push, no req_o.
- 6 back-to-back writes, ack_i held 0, FIFO_DEPTH=4:
  - without CPU_WAIT_EN → level 4, ovf_o=1, 4 writes delivered in order on release;
  - with the macro → wait_n=0 until space frees, all 6 delivered, ovf_o=0.
- Two writes queued then read of port 0, dbi_i=8'hC3 → read req only after both write acks; cd_o=8'hC3 with cd_oe=1 before the strobe ends.
- Access to addr 8'h9C, and access with rd_n and wr_n both low → no req_o, cd_oe=0.
- reset_n pulsed low with 3 entries queued and a read pending → all outputs at reset values immediately; no req_o after release.

Source files
------------

// File: rtl/cpu_io_bridge.sv
// rtl/cpu_io_bridge.sv - Z80 I/O-port bridge to the VDP register bus with filtered strobes and a write FIFO
// Define CPU_WAIT_EN to stall the CPU on reads and full-FIFO writes instead of dropping writes.

module cpu_io_bridge #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'h98,
    parameter int                NUM_PORTS  = 4,
    parameter int                FILTER_LEN = 3,
    parameter int                FIFO_DEPTH = 4,
    localparam int               PORT_W     = $clog2(NUM_PORTS),
    localparam int               LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              iorq_n_i,
    input  logic              rd_n_i,
    input  logic              wr_n_i,
    input  logic [7:0]        cd_i,
    output logic [7:0]        cd_o,
    output logic              cd_oe,
    output logic              wait_n,
    output logic              req_o,
    output logic              wrt_o,
    output logic [PORT_W-1:0] adr_o,
    output logic [7:0]        dbo_o,
    input  logic              ack_i,
    input  logic [7:0]        dbi_i,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic              ovf_o
);
    typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_REQ, END_WAIT} state_t;
    localparam int ENT_W = PORT_W + 8;

    state_t            state_q, state_d;
    logic              iorq_f, rd_f, wr_f;
    logic              hit, acc_rd, acc_end, idle_wr;
    logic [PORT_W-1:0] port_q;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
    logic [ENT_W-1:0]  fifo_wdata, fifo_rdata;
    logic              rd_start, vdp_ack, wr_hold;

    cpu_io_bridge_filter #(.FILTER_LEN(FILTER_LEN)) u_iorq_filt (
        .clk(clk), .reset_n(reset_n), .raw(iorq_n_i), .filt(iorq_f));
    cpu_io_bridge_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filt (
        .clk(clk), .reset_n(reset_n), .raw(rd_n_i), .filt(rd_f));
    cpu_io_bridge_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filt (
        .clk(clk), .reset_n(reset_n), .raw(wr_n_i), .filt(wr_f));

    cpu_io_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(fifo_push), .wdata(fifo_wdata),
        .pop(fifo_pop), .rdata(fifo_rdata), .level(fifo_level_o),
        .full(fifo_full), .empty(fifo_empty));

    assign hit      = ~iorq_f & (addr_i[ADDR_W-1:PORT_W] == BASE_ADDR[ADDR_W-1:PORT_W]);
    assign acc_rd   = hit & ~rd_f & wr_f;
    assign acc_end  = ~hit | (rd_f & wr_f);
    assign idle_wr  = (state_q == IDLE) & hit & rd_f & ~wr_f;
    assign vdp_ack  = req_o & ack_i;
    assign fifo_pop = vdp_ack & wrt_o;
    assign can_push = ~fifo_full | fifo_pop;
    // Reads wait behind every queued write so they never overtake one.
    assign rd_start = (state_q == RD_DRAIN) & fifo_empty & ~req_o;

`ifdef CPU_WAIT_EN
    logic             wr_pend_q;
    logic [ENT_W-1:0] pend_q;

    assign wr_hold    = wr_pend_q;
    assign fifo_push  = (idle_wr | wr_pend_q) & can_push;
    assign fifo_wdata = wr_pend_q ? pend_q : {addr_i[PORT_W-1:0], cd_i};
    assign ovf_o      = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_pend_q <= 1'b0;
            pend_q    <= '0;
            wait_n    <= 1'b1;
        end else begin
            if (idle_wr && !can_push) begin
                wr_pend_q <= 1'b1;
                pend_q    <= {addr_i[PORT_W-1:0], cd_i};
            end else if (wr_pend_q && can_push) begin
                wr_pend_q <= 1'b0;
            end
            if (((state_q == IDLE) && acc_rd) || (idle_wr && !can_push)) begin
                wait_n <= 1'b0;
            end else if (((state_q == RD_REQ) && vdp_ack) || (wr_pend_q && can_push)) begin
                wait_n <= 1'b1;
            end
        end
    end
`else
    assign wr_hold    = 1'b0;
    assign fifo_push  = idle_wr & can_push;
    assign fifo_wdata = {addr_i[PORT_W-1:0], cd_i};
    assign wait_n     = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_o <= 1'b0;
        end else if (idle_wr && !can_push) begin
            ovf_o <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_rd) begin
                    state_d = RD_DRAIN;
                end else if (hit && !(rd_f && wr_f)) begin
                    state_d = END_WAIT;
                end
            end
            RD_DRAIN: if (rd_start) state_d = RD_REQ;
            RD_REQ:   if (vdp_ack) state_d = END_WAIT;
            END_WAIT: if (acc_end && !wr_hold) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // An early-ending read still finishes on the VDP side; only the bus drive stops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q <= '0;
            cd_o   <= 8'h00;
            cd_oe  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && acc_rd) begin
                port_q <= addr_i[PORT_W-1:0];
                cd_oe  <= 1'b1;
            end else if ((state_q != IDLE) && acc_end) begin
                cd_oe <= 1'b0;
            end
            if ((state_q == RD_REQ) && vdp_ack) begin
                cd_o <= dbi_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_o <= 1'b0;
            wrt_o <= 1'b0;
            adr_o <= '0;
            dbo_o <= 8'h00;
        end else if (req_o) begin
            if (ack_i) req_o <= 1'b0;
        end else if (!fifo_empty) begin
            req_o          <= 1'b1;
            wrt_o          <= 1'b1;
            {adr_o, dbo_o} <= fifo_rdata;
        end else if (rd_start) begin
            req_o <= 1'b1;
            wrt_o <= 1'b0;
            adr_o <= port_q;
        end
    end
endmodule

module cpu_io_bridge_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filt
);
    logic [1:0] sync_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            cnt_q  <= 4'd0;
            filt   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == filt) begin
                cnt_q <= 4'd0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                filt  <= sync_q[1];
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end
endmodule

module cpu_io_bridge_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 10,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           push,
    input  logic [W-1:0]   wdata,
    input  logic           pop,
    output logic [W-1:0]   rdata,
    output logic [PTR_W:0] level,
    output logic           full,
    output logic           empty
);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                level <= level + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                level <= level - (PTR_W + 1)'(1);
            end
        end
    end
endmodule
